pipe_stage_skid: RTL and testbench

Parametrised pipeline-stage register that generalises the fixed ID/EX-style latch into a reusable stage for any boundary in the pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an arbitrary data payload and a control field between stages using a valid/ready handshake. An optional 2-entry skid buffer provides full throughput with a fully registered `o_ready`. It also supports synchronous flush with bubble injection and a saturating stall-cycle counter for performance analysis.

---
 rtl/pipe_stage_skid.sv | 110 +++++++++++
 tb/tb_pipe_stage_skid.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Reusable pipeline-stage register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush with bubble injection and a saturating stall counter.
module pipe_stage_skid #(
    parameter int unsigned       DATA_W      = 96,
    parameter int unsigned       CTRL_W      = 16,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
    parameter bit                SKID        = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [15:0]       o_stall_cnt
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  main_data, skid_data;
    logic [CTRL_W-1:0]  main_ctrl, skid_ctrl;
    logic [15:0]        stall_cnt;
    logic               accept, emit;
    logic               load_in, load_skid, load_from_skid;

    assign o_valid = (state != EMPTY);
    // With SKID the ready flag is a pure function of the state register; without it
    // the stage can refill in the same cycle it drains.
    assign o_ready = SKID ? (state != TWO) : (!o_valid || i_ready);
    assign accept  = i_valid && o_ready;
    assign emit    = o_valid && i_ready;

    assign o_data      = main_data;
    assign o_ctrl      = o_valid ? main_ctrl : CTRL_BUBBLE;
    assign o_stall_cnt = stall_cnt;

    always_comb begin
        state_nxt      = state;
        load_in        = 1'b0;
        load_skid      = 1'b0;
        load_from_skid = 1'b0;
        if (i_flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        load_in   = 1'b1;
                        state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (accept && (emit || !SKID)) begin
                        load_in = 1'b1;
                    end else if (emit) begin
                        state_nxt = EMPTY;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_nxt = TWO;
                    end
                end
                TWO: begin
                    if (emit) begin
                        load_from_skid = 1'b1;
                        state_nxt      = ONE;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= EMPTY;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            state <= state_nxt;
            if (load_in) begin
                main_data <= i_data;
                main_ctrl <= i_ctrl;
            end else if (load_from_skid) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
            end
            if (load_skid) begin
                skid_data <= i_data;
                skid_ctrl <= i_ctrl;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt <= '0;
        end else if (o_valid && !i_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector tables for both modes, stall-counter
// saturation, async reset, and randomized traffic against a queue-based model.
module tb_pipe_stage_skid;

    localparam logic [7:0] BUB1 = 8'h00;
    localparam logic [7:0] BUB0 = 8'h5A;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fl, vld, rdy;
    logic [31:0] din;
    logic [7:0]  cin;

    logic        rdy1, val1, rdy0, val0;
    logic [31:0] dat1, dat0;
    logic [7:0]  ctl1, ctl0;
    logic [15:0] cnt1_o, cnt0_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .CTRL_BUBBLE(BUB1), .SKID(1'b1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(fl), .i_valid(vld), .o_ready(rdy1),
        .i_data(din), .i_ctrl(cin), .o_valid(val1), .i_ready(rdy), .o_data(dat1),
        .o_ctrl(ctl1), .o_stall_cnt(cnt1_o)
    );

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .CTRL_BUBBLE(BUB0), .SKID(1'b0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(fl), .i_valid(vld), .o_ready(rdy0),
        .i_data(din), .i_ctrl(cin), .o_valid(val0), .i_ready(rdy), .o_data(dat0),
        .o_ctrl(ctl0), .o_stall_cnt(cnt0_o)
    );

    typedef struct {
        logic        v, r, f;
        logic [31:0] d;
        logic        ev, erdy;
        logic [31:0] ed;
        logic [7:0]  ec;
        logic [15:0] es;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [7:0]  c;
    } ent_t;

    vec_t tab[$];
    ent_t q1[$], q0[$];
    logic [31:0] last1, last0;
    int unsigned mcnt1, mcnt0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ctl_of(input logic [31:0] d);
        return 8'(d + 32'd16);
    endfunction

    task automatic add(input logic v, r, f, input logic [31:0] d, input logic ev, erdy,
                       input logic [31:0] ed, input logic [15:0] es, input logic [7:0] bub);
        vec_t x;
        x.v = v; x.r = r; x.f = f; x.d = d;
        x.ev = ev; x.erdy = erdy; x.ed = ed; x.es = es;
        x.ec = ev ? ctl_of(ed) : bub;
        tab.push_back(x);
    endtask

    task automatic do_reset();
        @(negedge clk);
        vld = 1'b0; rdy = 1'b0; fl = 1'b0; din = '0; cin = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q1.delete(); q0.delete();
        last1 = '0; last0 = '0; mcnt1 = 0; mcnt0 = 0;
    endtask

    task automatic run_table(input bit sel);
        for (int i = 0; i < tab.size(); i++) begin
            @(negedge clk);
            vld = tab[i].v; rdy = tab[i].r; fl = tab[i].f;
            din = tab[i].d; cin = ctl_of(tab[i].d);
            #1;
            if (sel) begin
                chk($sformatf("t1[%0d].valid", i), val1, tab[i].ev);
                chk($sformatf("t1[%0d].ready", i), rdy1, tab[i].erdy);
                chk($sformatf("t1[%0d].data", i), dat1, tab[i].ed);
                chk($sformatf("t1[%0d].ctrl", i), ctl1, tab[i].ec);
                chk($sformatf("t1[%0d].stall", i), cnt1_o, tab[i].es);
            end else begin
                chk($sformatf("t0[%0d].valid", i), val0, tab[i].ev);
                chk($sformatf("t0[%0d].ready", i), rdy0, tab[i].erdy);
                chk($sformatf("t0[%0d].data", i), dat0, tab[i].ed);
                chk($sformatf("t0[%0d].ctrl", i), ctl0, tab[i].ec);
                chk($sformatf("t0[%0d].stall", i), cnt0_o, tab[i].es);
            end
        end
        tab.delete();
    endtask

    // Reference behaviour: an ordered queue bounded at 2 (skid) or 1 (stall register).
    task automatic upd_models();
        ent_t e;
        bit   acc, em;
        e.d = din; e.c = cin;
        acc = vld && (q1.size() < 2);
        em  = (q1.size() > 0) && rdy;
        if (q1.size() > 0 && !rdy && mcnt1 < 32'hFFFF) mcnt1++;
        if (fl) q1.delete();
        else begin
            if (em) void'(q1.pop_front());
            if (acc) q1.push_back(e);
        end
        if (q1.size() > 0) last1 = q1[0].d;

        acc = vld && ((q0.size() == 0) || rdy);
        em  = (q0.size() > 0) && rdy;
        if (q0.size() > 0 && !rdy && mcnt0 < 32'hFFFF) mcnt0++;
        if (fl) q0.delete();
        else begin
            if (em) void'(q0.pop_front());
            if (acc) q0.push_back(e);
        end
        if (q0.size() > 0) last0 = q0[0].d;
    endtask

    task automatic chk_models();
        chk("r1.valid", val1, q1.size() > 0);
        chk("r1.ready", rdy1, q1.size() < 2);
        chk("r1.data", dat1, (q1.size() > 0) ? q1[0].d : last1);
        chk("r1.ctrl", ctl1, (q1.size() > 0) ? q1[0].c : BUB1);
        chk("r1.stall", cnt1_o, mcnt1);
        chk("r0.valid", val0, q0.size() > 0);
        chk("r0.ready", rdy0, (q0.size() == 0) || rdy);
        chk("r0.data", dat0, (q0.size() > 0) ? q0[0].d : last0);
        chk("r0.ctrl", ctl0, (q0.size() > 0) ? q0[0].c : BUB0);
        chk("r0.stall", cnt0_o, mcnt0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; vld = 1'b0; rdy = 1'b0; fl = 1'b0; din = '0; cin = '0;
        #1;
        chk("reset.valid", val1, 1'b0);
        chk("reset.ready", rdy1, 1'b1);
        chk("reset.data", dat1, 32'd0);
        chk("reset.ctrl", ctl1, BUB1);
        chk("reset.stall", cnt1_o, 16'd0);
        do_reset();

        // SKID=1: streaming, skid absorb, flush from TWO
        add(1,1,0, 32'h1, 0,1, 32'h0, 0, BUB1);
        add(1,1,0, 32'h2, 1,1, 32'h1, 0, BUB1);
        add(1,1,0, 32'h3, 1,1, 32'h2, 0, BUB1);
        add(1,1,0, 32'h4, 1,1, 32'h3, 0, BUB1);
        add(0,1,0, 32'h0, 1,1, 32'h4, 0, BUB1);
        add(0,1,0, 32'h0, 0,1, 32'h4, 0, BUB1);
        add(1,1,0, 32'hA, 0,1, 32'h4, 0, BUB1);
        add(1,0,0, 32'hB, 1,1, 32'hA, 0, BUB1);
        add(0,0,0, 32'h0, 1,0, 32'hA, 1, BUB1);
        add(0,1,0, 32'h0, 1,0, 32'hA, 2, BUB1);
        add(0,1,0, 32'h0, 1,1, 32'hB, 2, BUB1);
        add(0,1,0, 32'h0, 0,1, 32'hB, 2, BUB1);
        add(1,0,0, 32'h11, 0,1, 32'hB, 2, BUB1);
        add(1,0,0, 32'h22, 1,1, 32'h11, 2, BUB1);
        add(1,0,1, 32'hC, 1,0, 32'h11, 3, BUB1);
        add(0,1,0, 32'h0, 0,1, 32'h11, 4, BUB1);
        add(0,1,0, 32'h0, 0,1, 32'h11, 4, BUB1);
        run_table(1'b1);

        // SKID=0: combinational ready, pass-through refill, flush drop
        do_reset();
        add(1,0,0, 32'h33, 0,1, 32'h0, 0, BUB0);
        add(0,0,0, 32'h0, 1,0, 32'h33, 0, BUB0);
        add(1,1,0, 32'h44, 1,1, 32'h33, 1, BUB0);
        add(0,1,0, 32'h0, 1,1, 32'h44, 1, BUB0);
        add(0,0,0, 32'h0, 0,1, 32'h44, 1, BUB0);
        add(1,1,1, 32'h55, 0,1, 32'h44, 1, BUB0);
        add(0,0,0, 32'h0, 0,1, 32'h44, 1, BUB0);
        run_table(1'b0);

        // Stall counter saturation, flush immunity, async reset from TWO
        do_reset();
        @(negedge clk); vld = 1'b1; din = 32'h77; cin = 8'h07; rdy = 1'b0;
        @(negedge clk); vld = 1'b0;
        repeat (70000) @(negedge clk);
        #1;
        chk("sat.cnt1", cnt1_o, 16'hFFFF);
        chk("sat.cnt0", cnt0_o, 16'hFFFF);
        repeat (5) @(negedge clk);
        #1;
        chk("sat.hold1", cnt1_o, 16'hFFFF);
        fl = 1'b1;
        @(negedge clk); fl = 1'b0;
        #1;
        chk("flush.valid1", val1, 1'b0);
        chk("flush.cnt1", cnt1_o, 16'hFFFF);
        chk("flush.cnt0", cnt0_o, 16'hFFFF);
        @(negedge clk); vld = 1'b1; din = 32'h88; cin = 8'h08;
        @(negedge clk); vld = 1'b1; din = 32'h99; cin = 8'h09;
        @(negedge clk); vld = 1'b0;
        #1;
        chk("two.ready1", rdy1, 1'b0);
        chk("two.data1", dat1, 32'h88);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.valid1", val1, 1'b0);
        chk("arst.ready1", rdy1, 1'b1);
        chk("arst.data1", dat1, 32'h0);
        chk("arst.ctrl1", ctl1, BUB1);
        chk("arst.cnt1", cnt1_o, 16'h0);
        chk("arst.valid0", val0, 1'b0);
        chk("arst.data0", dat0, 32'h0);
        chk("arst.cnt0", cnt0_o, 16'h0);

        // Randomized traffic against the queue model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            vld = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 9) < 6);
            fl  = ($urandom_range(0, 19) == 0);
            din = $urandom;
            cin = 8'($urandom_range(0, 255));
            #1;
            chk_models();
            upd_models();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
